msrv32_machine_control: RTL

- Trap/return sequencer for the msrv32 core; sits beside the stage-2 decoder and consumes its `illegal_instr_out`, `misaligned_load_out` and `misaligned_store_out`.
- Runs a 4-state FSM. It drives `pc_src` to the PC mux, a pipeline flush, and CSR-file strobes (cause, epc, mie).
- Returns `trap_taken_out` to the decoder's `trap_taken_in` so that a faulting store never issues `mem_wr_req`.
- Synchronises the three asynchronous interrupt lines.

---
 rtl/msrv32_pkg.sv | 61 ++++++
 rtl/msrv32_irq_sync.sv | 27 ++
 rtl/msrv32_machine_control.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 machine-mode trap/return sequencer:
// FSM states, PC mux selects, mcause codes and the trap-cause priority encoder.
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } mc_state_e;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_EPC  = 2'b01,
        PC_TRAP = 2'b10,
        PC_NEXT = 2'b11
    } pc_src_e;

    localparam logic [4:0] SYSTEM = 5'b11100;

    localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
    localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] CAUSE_M_EXT_IRQ        = 4'd11;
    localparam logic [3:0] CAUSE_M_SW_IRQ         = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER_IRQ      = 4'd7;

    typedef struct packed {
        logic [3:0] code;
        logic       irq;
        logic       misaligned;
    } trap_cause_t;

    // Fixed priority, highest first; exceptions always win over interrupts.
    function automatic trap_cause_t select_cause(
        input logic mis_instr,
        input logic illegal,
        input logic ebreak,
        input logic mis_load,
        input logic mis_store,
        input logic ecall,
        input logic ext_irq,
        input logic sw_irq
    );
        trap_cause_t c;
        if (mis_instr)      c = '{code: CAUSE_MISALIGNED_INSTR, irq: 1'b0, misaligned: 1'b1};
        else if (illegal)   c = '{code: CAUSE_ILLEGAL_INSTR,    irq: 1'b0, misaligned: 1'b0};
        else if (ebreak)    c = '{code: CAUSE_BREAKPOINT,       irq: 1'b0, misaligned: 1'b0};
        else if (mis_load)  c = '{code: CAUSE_MISALIGNED_LOAD,  irq: 1'b0, misaligned: 1'b1};
        else if (mis_store) c = '{code: CAUSE_MISALIGNED_STORE, irq: 1'b0, misaligned: 1'b1};
        else if (ecall)     c = '{code: CAUSE_ECALL_M,          irq: 1'b0, misaligned: 1'b0};
        else if (ext_irq)   c = '{code: CAUSE_M_EXT_IRQ,        irq: 1'b1, misaligned: 1'b0};
        else if (sw_irq)    c = '{code: CAUSE_M_SW_IRQ,         irq: 1'b1, misaligned: 1'b0};
        else                c = '{code: CAUSE_M_TIMER_IRQ,      irq: 1'b1, misaligned: 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/msrv32_irq_sync.sv
// N-flop level synchroniser for one asynchronous interrupt line, cleared by
// the asynchronous active-low core reset.
module msrv32_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic irq_i,
    output logic irq_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES:0]   shift_in;

    assign shift_in = {sync_q, irq_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= shift_in[STAGES-1:0];
        end
    end

    assign irq_o = sync_q[STAGES-1];

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return sequencer: picks the trap cause, steers the PC mux,
// flushes stage 2 and strobes the CSR file on trap entry and mret.
module msrv32_machine_control
    import msrv32_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_n_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       e_irq_in,
    input  logic       t_irq_in,
    input  logic       s_irq_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    output logic       meip_out,
    output logic       mtip_out,
    output logic       msip_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       trap_taken_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       misaligned_exception_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out
);

    logic [2:0] irq_raw;
    logic [2:0] irq_sync;

    assign irq_raw = {s_irq_in, t_irq_in, e_irq_in};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_irq_sync
            msrv32_irq_sync #(
                .STAGES(IRQ_SYNC_STAGES)
            ) u_sync (
                .clk_i (ms_riscv32_mp_clk_in),
                .rst_ni(ms_riscv32_mp_rst_n_in),
                .irq_i (irq_raw[gi]),
                .irq_o (irq_sync[gi])
            );
        end
    endgenerate

    assign meip_out = irq_sync[0];
    assign mtip_out = irq_sync[1];
    assign msip_out = irq_sync[2];

    logic is_system, is_ecall, is_ebreak, is_mret;
    logic exception, ext_irq, tmr_irq, sw_irq, irq_pend, trap_taken;
    trap_cause_t cause_sel;

    assign is_system = (opcode_6_to_2_in == SYSTEM) && (funct3_in == 3'b000) &&
                       (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign is_ecall  = is_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
    assign is_ebreak = is_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
    assign is_mret   = is_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

    assign exception = illegal_instr_in | misaligned_load_in | misaligned_store_in |
                       misaligned_instr_in | is_ecall | is_ebreak;
    assign ext_irq   = meie_in & meip_out;
    assign tmr_irq   = mtie_in & mtip_out;
    assign sw_irq    = msie_in & msip_out;
    assign irq_pend  = mie_in & (ext_irq | tmr_irq | sw_irq);

    mc_state_e   state_q;
    pc_src_e     pc_src_q;
    logic        flush_q, trap_strobe_q, mie_set_q;
    logic [3:0]  cause_q;
    logic        i_or_e_q, misaligned_q;

    assign trap_taken = (state_q == ST_OPERATING) && (exception || irq_pend);
    assign cause_sel  = select_cause(misaligned_instr_in, illegal_instr_in, is_ebreak,
                                     misaligned_load_in, misaligned_store_in, is_ecall,
                                     ext_irq, sw_irq);

    // Outputs are registered for the state being entered, so they are pure
    // functions of the current state as seen by the rest of the core.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q       <= ST_RESET;
            pc_src_q      <= PC_BOOT;
            flush_q       <= 1'b1;
            trap_strobe_q <= 1'b0;
            mie_set_q     <= 1'b0;
            cause_q       <= 4'd0;
            i_or_e_q      <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= ST_OPERATING;
            pc_src_q      <= PC_NEXT;
            flush_q       <= 1'b0;
            trap_strobe_q <= 1'b0;
            mie_set_q     <= 1'b0;
            if (state_q == ST_OPERATING) begin
                if (trap_taken) begin
                    state_q       <= ST_TRAP_TAKEN;
                    pc_src_q      <= PC_TRAP;
                    flush_q       <= 1'b1;
                    trap_strobe_q <= 1'b1;
                    cause_q       <= cause_sel.code;
                    i_or_e_q      <= cause_sel.irq;
                    misaligned_q  <= cause_sel.misaligned;
                end else if (is_mret) begin
                    state_q   <= ST_TRAP_RETURN;
                    pc_src_q  <= PC_EPC;
                    flush_q   <= 1'b1;
                    mie_set_q <= 1'b1;
                end
            end
        end
    end

    assign trap_taken_out           = trap_taken;
    assign instret_inc_out          = (state_q == ST_OPERATING) && !trap_taken;
    assign pc_src_out               = pc_src_q;
    assign flush_out                = flush_q;
    assign set_cause_out            = trap_strobe_q;
    assign set_epc_out              = trap_strobe_q;
    assign mie_clear_out            = trap_strobe_q;
    assign mie_set_out              = mie_set_q;
    assign cause_out                = cause_q;
    assign i_or_e_out               = i_or_e_q;
    assign misaligned_exception_out = misaligned_q;

endmodule
